window_3x3_gen: RTL and testbench
=================================

WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 1920, pixels per line (3..2000).
REQ-002 SHALL have parameter IMG_HEIGHT, default 1080, lines per frame (3..2047).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pix_in  input  8  incoming pixel, raster order.
REQ-006 SHALL have port pix_valid  input  1  pix_in valid; one pixel accepted per cycle when high; no backpressure.
REQ-007 SHALL have port sof  input  1  start of frame, qualified by pix_valid; marks pixel (row 0, col 0).
REQ-008 SHALL have port win_out  output  72  3x3 window; byte 3*i+j holds pixel(row r-2+i, col c-2+j).
REQ-009 SHALL have port win_valid  output  1  win_out valid, one-cycle pulse per window.

Function
REQ-010 SHALL contain two internal line memories of IMG_WIDTH x 8 bits: lb0 (row r-1) and lb1 (row r-2), addressed by column, synchronous read with 1-cycle latency, read-first.
REQ-011 SHALL keep an 11-bit column counter and an 11-bit row counter; column wraps IMG_WIDTH-1 -> 0 and increments row.
REQ-012 SHALL run FSM IDLE -> FILL on accepted pixel with sof; FILL -> RUN after last pixel of row 1; RUN -> IDLE after pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-013 SHALL drop pixels accepted in IDLE without sof: no counter, memory or output change.
REQ-014 SHALL, at accepted pixel (r,c) in cycle t, read lb0[c] and lb1[c]; at t+1 write lb0[c]<=pixel, lb1[c]<=old lb0[c].
REQ-015 SHALL, at t+1, shift column {lb1[c], lb0[c], pixel} into a 3x3 register array, oldest column leaving.
REQ-016 SHALL assert win_valid at t+2 (fixed 2-cycle latency) only when r>=2 and c>=2; (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows per frame.
REQ-017 SHALL hold win_out unchanged while no pixel advances the pipeline; gaps in pix_valid stall nothing else.
REQ-018 SHALL treat sof during FILL/RUN as frame restart: that pixel becomes (0,0), FSM enters FILL, in-flight windows of the old frame still emerge.
REQ-019 SHALL never form a window spanning a row boundary (c<2 suppresses win_valid).

Reset
REQ-020 SHALL on rst_n low clear counters, FSM to IDLE, win_valid to 0, win_out to 0, pipeline valids to 0, immediately and asynchronously.
REQ-021 SHALL not clear line memory contents on reset; after reset the next frame refills them before use.
REQ-022 SHALL on reset mid-frame discard in-flight pixels; no win_valid until a new sof-frame reaches row 2, col 2.

Configuration
REQ-023 SHALL, when macro WINDOW_FRAME_DONE_EN is defined, add output port frame_done (1 bit, reset 0) pulsing one cycle together with win_valid of the frame's last window.
REQ-024 SHALL, when WINDOW_FRAME_DONE_EN is undefined, omit frame_done and its logic; all other behaviour identical.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = 4r+c)
REQ-025 SHALL cover: continuous frame with sof on first pixel -> 4 win_valid pulses; first at 2 cycles after pixel 10, win_out bytes 0..8 = 0,1,2,4,5,6,8,9,10; last = 5,6,7,9,10,11,13,14,15.
REQ-026 SHALL cover: same frame with pix_valid low every other cycle -> same 4 windows, each 2 cycles after its pixel, win_out stable between.
REQ-027 SHALL cover: 5 pixels with pix_valid high and sof low from IDLE, then a valid frame -> no win_valid from the first 5; identical windows to REQ-025.
REQ-028 SHALL cover: sof reasserted at row 2 col 1, then full frame -> no window from the aborted frame after restart; 4 correct windows of new frame.
REQ-029 SHALL cover: rst_n low for 1 cycle at pixel 11 -> win_valid 0 immediately; next sof-frame yields 4 correct windows.
REQ-030 SHALL cover, with WINDOW_FRAME_DONE_EN defined: continuous frame -> frame_done high exactly once, same cycle as 4th win_valid.

Source files
------------

// File: rtl/window_3x3_gen_if.sv
// Pixel stream in, 3x3 window stream out for window_3x3_gen.
interface window_3x3_gen_if;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        sof;
    logic [71:0] win_out;
    logic        win_valid;

    modport master (output pix_in, pix_valid, sof, input win_out, win_valid);
    modport slave  (input pix_in, pix_valid, sof, output win_out, win_valid);
endinterface

// File: rtl/window_3x3_gen.sv
// 3x3 sliding window generator over a raster pixel stream using two line buffers.
// Optional WINDOW_FRAME_DONE_EN adds a frame_done pulse on the frame's last window.
module window_3x3_gen #(
    parameter int IMG_WIDTH  = 1920,
    parameter int IMG_HEIGHT = 1080
) (
    input  logic clk,
    input  logic rst_n,
    window_3x3_gen_if.slave bus
`ifdef WINDOW_FRAME_DONE_EN
    ,
    output logic frame_done
`endif
);
    localparam int          AW       = $clog2(IMG_WIDTH);
    localparam logic [10:0] COL_LAST = 11'(IMG_WIDTH - 1);
    localparam logic [10:0] ROW_LAST = 11'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
    state_t state_q, state_d;

    logic [10:0] col_q, row_q, pos_col, pos_row;
    logic        acc, eol, eof;

    // sof forces the current pixel to (0,0) regardless of where the counters are.
    always_comb begin
        acc     = bus.pix_valid && (bus.sof || state_q != IDLE);
        pos_col = bus.sof ? 11'd0 : col_q;
        pos_row = bus.sof ? 11'd0 : row_q;
        eol     = (pos_col == COL_LAST);
        eof     = eol && (pos_row == ROW_LAST);
    end

    always_comb begin
        state_d = state_q;
        if (acc) begin
            if (bus.sof) state_d = FILL;
            else begin
                case (state_q)
                    FILL:    if (eol && pos_row == 11'd1) state_d = RUN;
                    RUN:     if (eof) state_d = IDLE;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            if (acc) begin
                col_q <= eol ? 11'd0 : pos_col + 11'd1;
                row_q <= eof ? 11'd0 : (eol ? pos_row + 11'd1 : pos_row);
            end
        end
    end

    // Stage 1: pixel waits here while the line buffers return its column.
    logic          p1_vld, p1_win, p1_last;
    logic [7:0]    p1_pix;
    logic [AW-1:0] p1_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_vld  <= 1'b0;
            p1_win  <= 1'b0;
            p1_last <= 1'b0;
            p1_pix  <= '0;
            p1_col  <= '0;
        end else begin
            p1_vld  <= acc;
            p1_win  <= acc && pos_row >= 11'd2 && pos_col >= 11'd2;
            p1_last <= acc && eof;
            if (acc) begin
                p1_pix <= bus.pix_in;
                p1_col <= pos_col[AW-1:0];
            end
        end
    end

    // Line buffers are never reset; a new frame rewrites them before rows 0/1 are consumed.
    logic [7:0] lb0 [0:IMG_WIDTH-1];
    logic [7:0] lb1 [0:IMG_WIDTH-1];
    logic [7:0] rd0, rd1;

    always_ff @(posedge clk) begin
        if (acc) begin
            rd0 <= lb0[pos_col[AW-1:0]];
            rd1 <= lb1[pos_col[AW-1:0]];
        end
        if (p1_vld) begin
            lb0[p1_col] <= p1_pix;
            lb1[p1_col] <= rd0;
        end
    end

    // Byte 3*i+j: row i (0 = oldest line), column j (2 = newest).
    logic [2:0][7:0] col_new;
    logic [71:0]     win_q;
    logic            win_vld;

    always_comb begin
        col_new[0] = rd1;
        col_new[1] = rd0;
        col_new[2] = p1_pix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q   <= '0;
            win_vld <= 1'b0;
        end else begin
            win_vld <= p1_win;
            if (p1_vld) begin
                for (int i = 0; i < 3; i++) begin
                    win_q[8*(3*i)   +: 8] <= win_q[8*(3*i+1) +: 8];
                    win_q[8*(3*i+1) +: 8] <= win_q[8*(3*i+2) +: 8];
                    win_q[8*(3*i+2) +: 8] <= col_new[i];
                end
            end
        end
    end

    assign bus.win_out   = win_q;
    assign bus.win_valid = win_vld;

`ifdef WINDOW_FRAME_DONE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_done <= 1'b0;
        else        frame_done <= p1_last;
    end
`endif
endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen: image-level reference model, queue of expected windows.
module tb_window_3x3_gen;
    localparam int W = 4;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    window_3x3_gen_if bus();
`ifdef WINDOW_FRAME_DONE_EN
    logic frame_done;
`endif

    window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef WINDOW_FRAME_DONE_EN
        , .frame_done(frame_done)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [71:0] win;
        int          cyc;
        bit          last;
    } exp_t;

    exp_t       q[$];
    bit         acc_log[int];
    int         ntests = 0;
    int         nfail  = 0;
    logic [7:0] img [H][W];
    bit         in_frame = 0;
    int         mr = 0, mc = 0;
    logic [71:0] prev_win = '0;

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: track image position of each accepted pixel, emit a window whenever
    // the 3x3 neighbourhood ending at (r,c) lies completely inside the current frame.
    task automatic drive(input bit v, input bit s, input logic [7:0] p);
        exp_t e;
        @(posedge clk); #1;
        bus.pix_valid = v;
        bus.sof       = s;
        bus.pix_in    = p;
        if (v && s) begin
            in_frame = 1; mr = 0; mc = 0;
        end
        if (v && in_frame) begin
            acc_log[cyc] = 1'b1;
            img[mr][mc] = p;
            if (mr >= 2 && mc >= 2) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e.win[8*(3*i+j) +: 8] = img[mr-2+i][mc-2+j];
                e.cyc  = cyc + 2;
                e.last = (mr == H-1 && mc == W-1);
                q.push_back(e);
            end
            if (mc == W-1) begin
                mc = 0;
                if (mr == H-1) in_frame = 0;
                else mr++;
            end else mc++;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input bit gaps);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                drive(1'b1, (r == 0 && c == 0), 8'(4*r + c));
                if (gaps) drive(1'b0, 1'b0, 8'hA5);
            end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.pix_valid = 1'b0;
        bus.sof = 1'b0;
        q.delete();
        in_frame = 0;
        #1;
        check("reset_win_valid", 72'(bus.win_valid), 72'd0);
        check("reset_win_out", bus.win_out, 72'd0);
`ifdef WINDOW_FRAME_DONE_EN
        check("reset_frame_done", 72'(frame_done), 72'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) prev_win = '0;
        else begin
            if (bus.win_valid) begin
                if (q.size() == 0) check("unexpected_window", 72'd1, 72'd0);
                else begin
                    e = q.pop_front();
                    check("win_out", bus.win_out, e.win);
                    check("win_latency", 72'(cyc), 72'(e.cyc));
`ifdef WINDOW_FRAME_DONE_EN
                    check("frame_done", 72'(frame_done), 72'(e.last));
`endif
                end
            end else begin
`ifdef WINDOW_FRAME_DONE_EN
                check("frame_done_idle", 72'(frame_done), 72'd0);
`endif
                if (!acc_log.exists(cyc - 2)) check("win_out_hold", bus.win_out, prev_win);
                if (q.size() != 0 && q[0].cyc < cyc) begin
                    check("missing_window", 72'd0, 72'd1);
                    void'(q.pop_front());
                end
            end
            prev_win = bus.win_out;
        end
    end

    initial begin
        bus.pix_in = '0;
        bus.pix_valid = 1'b0;
        bus.sof = 1'b0;
        do_reset();

        // Continuous frame, then the same frame with a gap every other cycle.
        send_frame(1'b0); idle(4);
        send_frame(1'b1); idle(4);

        // Junk pixels while idle are dropped.
        do_reset();
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, 8'(8'hF0 + k));
        send_frame(1'b0); idle(4);

        // Restart at row 2 col 1; the sof pixel begins the new frame.
        for (int k = 0; k < 9; k++) drive(1'b1, (k == 0), 8'(8'h40 + k));
        send_frame(1'b0); idle(4);

        // Reset in place of pixel 11, then a fresh frame.
        for (int k = 0; k < 11; k++) drive(1'b1, (k == 0), 8'(k));
        do_reset();
        check("post_reset_queue", 72'(q.size()), 72'd0);
        send_frame(1'b0); idle(4);

        // Random stream: gaps, idle junk, and occasional mid-frame restarts.
        for (int k = 0; k < 600; k++) begin
            bit v, s;
            v = ($urandom_range(0, 2) != 0);
            s = in_frame ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 3) == 0);
            drive(v, s, 8'($urandom));
        end
        idle(6);
        check("final_queue_empty", 72'(q.size()), 72'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
